bfly11_stage: RTL

//  Radix-2 butterfly for stage 11 of the 16-lane parallel FFT; directly feeds twd_mul11.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/bfly11_delay_buf.sv | 27 ++
 rtl/bfly11_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the 16-lane parallel FFT pipeline stages.
package fft_pkg;

    localparam int FFT_LANES    = 16;
    localparam int BFLY11_IN_W  = 12;
    localparam int BFLY11_DEPTH = 8;

    // Position within an SDF butterfly frame: first half buffered, second half combined.
    typedef enum logic {
        PH_FILL    = 1'b0,
        PH_COMPUTE = 1'b1
    } phase_t;

    typedef struct packed {
        logic signed [BFLY11_IN_W-1:0] re;
        logic signed [BFLY11_IN_W-1:0] im;
    } cplx11_t;

    typedef cplx11_t [FFT_LANES-1:0] lanes11_t;

endpackage

// File: rtl/bfly11_delay_buf.sv
// DEPTH-entry register file holding one half-frame of beats for an SDF butterfly.
// Single write port, asynchronous read port.
module bfly11_delay_buf #(
    parameter int WORD_W = 384,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; every entry is rewritten in the fill phase before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bfly11_stage.sv
// Stage-11 radix-2 SDF butterfly: buffers the first DEPTH beats of a frame, then emits
// registered sum/diff of each later beat with its buffered partner on all lanes.
module bfly11_stage
    import fft_pkg::*;
#(
    parameter int IN_W  = BFLY11_IN_W,
    parameter int LANES = FFT_LANES,
    parameter int DEPTH = BFLY11_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic signed [IN_W-1:0] i_data_re      [0:LANES-1],
    input  logic signed [IN_W-1:0] i_data_im      [0:LANES-1],
    output logic                   o_valid,
    output logic signed [IN_W:0]   o_bfly_sum_re  [0:LANES-1],
    output logic signed [IN_W:0]   o_bfly_sum_im  [0:LANES-1],
    output logic signed [IN_W:0]   o_bfly_diff_re [0:LANES-1],
    output logic signed [IN_W:0]   o_bfly_diff_im [0:LANES-1],
    output logic                   o_frame_done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int WORD_W = LANES * 2 * IN_W;

    logic [CW-1:0]     cnt;
    phase_t            phase;
    logic [AW-1:0]     k;
    logic              buf_we;
    logic [WORD_W-1:0] buf_wdata;
    logic [WORD_W-1:0] buf_rdata;

    logic signed [IN_W-1:0] buf_re   [0:LANES-1];
    logic signed [IN_W-1:0] buf_im   [0:LANES-1];
    logic signed [IN_W:0]   sum_re_d [0:LANES-1];
    logic signed [IN_W:0]   sum_im_d [0:LANES-1];
    logic signed [IN_W:0]   diff_re_d[0:LANES-1];
    logic signed [IN_W:0]   diff_im_d[0:LANES-1];

    // Top counter bit is the half-frame flag; low bits address the buffer in both halves.
    assign phase  = phase_t'(cnt[AW]);
    assign k      = cnt[AW-1:0];
    assign buf_we = i_valid && !rst && (phase == PH_FILL);

    bfly11_delay_buf #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_delay_buf (
        .clk    (clk),
        .we     (buf_we),
        .waddr  (k),
        .wdata  (buf_wdata),
        .raddr  (k),
        .rdata  (buf_rdata)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        buf_wdata = '0;
        for (int l = 0; l < LANES; l++) begin
            buf_wdata[l*2*IN_W +: IN_W]        = i_data_re[l];
            buf_wdata[l*2*IN_W + IN_W +: IN_W] = i_data_im[l];
        end
    end

    // Both operands are sign-extended by one bit, so the full input range is exact.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            buf_re[l]    = buf_rdata[l*2*IN_W +: IN_W];
            buf_im[l]    = buf_rdata[l*2*IN_W + IN_W +: IN_W];
            sum_re_d[l]  = (IN_W+1)'(buf_re[l]) + (IN_W+1)'(i_data_re[l]);
            sum_im_d[l]  = (IN_W+1)'(buf_im[l]) + (IN_W+1)'(i_data_im[l]);
            diff_re_d[l] = (IN_W+1)'(buf_re[l]) - (IN_W+1)'(i_data_re[l]);
            diff_im_d[l] = (IN_W+1)'(buf_im[l]) - (IN_W+1)'(i_data_im[l]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                o_bfly_sum_re[l]  <= '0;
                o_bfly_sum_im[l]  <= '0;
                o_bfly_diff_re[l] <= '0;
                o_bfly_diff_im[l] <= '0;
            end
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_valid) begin
                // 2*DEPTH is a power of two, so the natural wrap returns to beat 0.
                cnt <= cnt + CW'(1);
                if (phase == PH_COMPUTE) begin
                    o_valid      <= 1'b1;
                    o_frame_done <= (k == AW'(DEPTH - 1));
                    for (int l = 0; l < LANES; l++) begin
                        o_bfly_sum_re[l]  <= sum_re_d[l];
                        o_bfly_sum_im[l]  <= sum_im_d[l];
                        o_bfly_diff_re[l] <= diff_re_d[l];
                        o_bfly_diff_im[l] <= diff_im_d[l];
                    end
                end
            end
        end
    end

endmodule
